// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core's execute stage and the iterative
// RV32M multiply/divide unit.
interface mul_div_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] result;
   logic            done;
   logic            alu_complete;

   modport master (
      output start, funct3, op_a, op_b,
      input  result, done, alu_complete
   );

   modport slave (
      input  start, funct3, op_a, op_b,
      output result, done, alu_complete
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: fixed 35-edge sequence per op, alu_complete
// low while busy so the phase-clock generator stalls the core.
//
// state  | meaning
// IDLE   | waiting for start; operands and funct3 latched on start
// PREP   | derive operand signs, load magnitudes, clear accumulator
// CALC   | 32 shift-add (mul) or restoring-subtract (div) iterations
// FIX    | apply signs / special cases, present result, pulse done
module mul_div_unit #(
   parameter int XLEN = 32
) (
   input logic           clk_100M,
   input logic           rst,
   mul_div_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_CALC,
      S_FIX
   } state_t;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, state_nxt;
   logic [2:0]        fn_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic [XLEN-1:0]   sh_b;
   logic [2*XLEN-1:0] acc, sh_a;
   logic [4:0]        iter;
   logic              neg_a, neg_b;
   logic [XLEN-1:0]   result_q;
   logic              done_q, alu_complete_q;

   logic              is_div, sgn_a, sgn_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     rem_shift, diff;
   logic              rem_ge;
   logic [2*XLEN-1:0] mul_addend, prod_fix;
   logic [XLEN-1:0]   quo, rem;
   logic              b_zero, ovf;
   logic [XLEN-1:0]   res_fix;

   assign bus.result       = result_q;
   assign bus.done         = done_q;
   assign bus.alu_complete = alu_complete_q;

   always_ff @(posedge clk_100M) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_PREP;
         S_PREP:  state_nxt = S_CALC;
         S_CALC:  if (iter == 5'd31) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand signedness: MULHSU treats only rs1 as signed; the U ops neither.
   always_comb begin
      is_div = fn_q[2];
      sgn_a  = !(fn_q == 3'b011 || fn_q == 3'b101 || fn_q == 3'b111);
      sgn_b  = (fn_q == 3'b000 || fn_q == 3'b001 || fn_q == 3'b100 || fn_q == 3'b110);
      mag_a  = (sgn_a && a_q[XLEN-1]) ? -a_q : a_q;
      mag_b  = (sgn_b && b_q[XLEN-1]) ? -b_q : b_q;
   end

   // One restoring-division step and one shift-add multiply step.
   always_comb begin
      rem_shift  = {acc[XLEN-1:0], sh_a[XLEN-1]};
      rem_ge     = (rem_shift >= {1'b0, sh_b});
      diff       = rem_shift - {1'b0, sh_b};
      mul_addend = sh_b[0] ? sh_a : '0;
   end

   always_comb begin
      prod_fix = (neg_a ^ neg_b) ? -acc : acc;
      quo      = sh_a[XLEN-1:0];
      rem      = acc[XLEN-1:0];
      b_zero   = (b_q == '0);
      ovf      = (a_q == INT_MIN) && (b_q == '1);
      res_fix  = '0;
      case (fn_q)
         3'b000:  res_fix = prod_fix[XLEN-1:0];
         3'b001,
         3'b010,
         3'b011:  res_fix = prod_fix[2*XLEN-1:XLEN];
         3'b100: begin
            if (b_zero)           res_fix = '1;
            else if (ovf)         res_fix = INT_MIN;
            else if (neg_a ^ neg_b) res_fix = -quo;
            else                  res_fix = quo;
         end
         3'b101:  res_fix = b_zero ? '1 : quo;
         3'b110: begin
            if (b_zero)     res_fix = a_q;
            else if (ovf)   res_fix = '0;
            else if (neg_a) res_fix = -rem;
            else            res_fix = rem;
         end
         3'b111:  res_fix = b_zero ? a_q : rem;
         default: res_fix = '0;
      endcase
   end

   always_ff @(posedge clk_100M) begin
      if (rst) begin
         fn_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         sh_a           <= '0;
         sh_b           <= '0;
         acc            <= '0;
         iter           <= '0;
         neg_a          <= 1'b0;
         neg_b          <= 1'b0;
         result_q       <= '0;
         done_q         <= 1'b0;
         alu_complete_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  fn_q           <= bus.funct3;
                  a_q            <= bus.op_a;
                  b_q            <= bus.op_b;
                  alu_complete_q <= 1'b0;
               end
            end
            S_PREP: begin
               neg_a <= sgn_a & a_q[XLEN-1];
               neg_b <= sgn_b & b_q[XLEN-1];
               sh_a  <= {{XLEN{1'b0}}, mag_a};
               sh_b  <= mag_b;
               acc   <= '0;
               iter  <= '0;
            end
            S_CALC: begin
               iter <= iter + 5'd1;
               if (is_div) begin
                  // Remainder never exceeds the divisor, so XLEN+1 bits suffice.
                  acc  <= {{(XLEN-1){1'b0}}, rem_ge ? diff : rem_shift};
                  sh_a <= {{XLEN{1'b0}}, sh_a[XLEN-2:0], rem_ge};
               end else begin
                  acc  <= acc + mul_addend;
                  sh_a <= {sh_a[2*XLEN-2:0], 1'b0};
                  sh_b <= {1'b0, sh_b[XLEN-1:1]};
               end
            end
            S_FIX: begin
               result_q       <= res_fix;
               done_q         <= 1'b1;
               alu_complete_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, protocol sequences
// and randomized ops against an arithmetic reference model.
module tb_mul_div_unit;
   logic clk_100M = 1'b0;
   logic rst;
   always #5 clk_100M = ~clk_100M;

   mul_div_unit_if #(.XLEN(32)) bus ();
   mul_div_unit #(.XLEN(32)) dut (.clk_100M(clk_100M), .rst(rst), .bus(bus));

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk_100M) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: RV32M semantics from plain 64-bit and 32-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          ia, ib;
      ia = a;
      ib = b;
      sa = longint'(ia);
      sb = longint'(ib);
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issues one op and checks result, done edge offset, busy length and done fall.
   // pulse_at >= 0 drives a stray start sampled at edge E+pulse_at.
   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int pulse_at);
      int          done_edge, low_cnt;
      logic [31:0] res;
      @(negedge clk_100M);
      bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
      @(posedge clk_100M); #1;
      bus.start = 1'b0;
      bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom_range(0, 7));
      done_edge = -1; low_cnt = 0; res = 'x;
      for (int k = 0; k <= 60; k++) begin
         if (k > 0) begin @(posedge clk_100M); #1; end
         if (k == pulse_at) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            done_edge = k; res = bus.result;
            chk({name, " alu_complete@done"}, 32'(bus.alu_complete), 32'd1);
            break;
         end
         if (bus.alu_complete === 1'b0) low_cnt++;
         if (k + 1 == pulse_at) bus.start = 1'b1;
      end
      bus.start = 1'b0;
      chk({name, " result"}, res, exp);
      chk({name, " done edge"}, 32'(done_edge), 32'd34);
      chk({name, " busy cycles"}, 32'(low_cnt), 32'd34);
      @(posedge clk_100M); #1;
      chk({name, " done fall"}, 32'(bus.done), 32'd0);
   endtask

   task automatic wait_done(output int c, output bit ok);
      ok = 1'b0; c = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk_100M); #1;
         if (bus.done === 1'b1) begin c = cyc; ok = 1'b1; return; end
      end
   endtask

   initial begin
      int          c1, c2, c3, cnt, low;
      bit          ok1, ok2, ok3;
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [31:0] specials[6];

      specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
      vecs = '{
         '{"MUL -1*2",         3'd0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE},
         '{"MULHU ffffffff*2", 3'd3, 32'hFFFF_FFFF, 32'h2,         32'h1},
         '{"MULH -1*-1",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0},
         '{"MULHSU -1*ffff",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         '{"DIV -7/2",         3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD},
         '{"REM -7/2",         3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF},
         '{"DIVU fff9/2",      3'd5, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC},
         '{"DIVU 5/0",         3'd5, 32'h5,         32'h0,         32'hFFFF_FFFF},
         '{"REMU 5/0",         3'd7, 32'h5,         32'h0,         32'h5},
         '{"DIV ovf",          3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
         '{"REM ovf",          3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
         '{"DIV 5/0",          3'd4, 32'h5,         32'h0,         32'hFFFF_FFFF},
         '{"REM -7/0",         3'd6, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9}
      };

      rst = 1'b1; bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
      repeat (3) @(posedge clk_100M);
      #1;
      chk("reset result", bus.result, 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset alu_complete", 32'(bus.alu_complete), 32'd1);
      @(negedge clk_100M);
      bus.start = 1'b0; rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, -1);

      // Stray start mid-CALC must be ignored.
      run_op("start mid-CALC", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 12);
      low = 0;
      repeat (40) begin
         @(posedge clk_100M); #1;
         if (bus.alu_complete !== 1'b1) low++;
      end
      chk("no op after stray start", 32'(low), 32'd0);

      // start held high: one op per 35 edges.
      @(negedge clk_100M);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd7; bus.op_b = 32'd6;
      wait_done(c1, ok1);
      chk("held op1 result", bus.result, 32'd42);
      wait_done(c2, ok2);
      wait_done(c3, ok3);
      bus.start = 1'b0;
      chk("held op3 result", bus.result, 32'd42);
      chk("held done seen", 32'({ok1, ok2, ok3}), 32'b111);
      chk("held spacing 1-2", 32'(c2 - c1), 32'd35);
      chk("held spacing 2-3", 32'(c3 - c2), 32'd35);
      cnt = 0;
      repeat (40) begin
         @(posedge clk_100M); #1;
         if (bus.done === 1'b1) cnt++;
      end
      chk("held no extra done", 32'(cnt), 32'd0);

      // Reset asserted at E+10 aborts the op silently.
      run_op("pre-reset MUL", 3'd0, 32'd3, 32'd5, 32'd15, -1);
      @(negedge clk_100M);
      bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd100; bus.op_b = 32'd7;
      @(posedge clk_100M); #1;
      bus.start = 1'b0;
      cnt = 0; low = 0;
      for (int k = 0; k <= 60; k++) begin
         if (k > 0) begin @(posedge clk_100M); #1; end
         if (k == 10) begin
            rst = 1'b0;
            chk("rst mid-CALC alu_complete", 32'(bus.alu_complete), 32'd1);
            chk("rst mid-CALC result", bus.result, 32'd0);
         end
         if (bus.done === 1'b1) cnt++;
         if (k > 10 && bus.alu_complete !== 1'b1) low++;
         if (k == 9) rst = 1'b1;
      end
      chk("rst mid-CALC no done", 32'(cnt), 32'd0);
      chk("rst mid-CALC stays idle", 32'(low), 32'd0);
      run_op("post-reset DIVU", 3'd5, 32'd100, 32'd7, 32'd14, -1);

      for (int n = 0; n < 48; n++) begin
         f = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         run_op($sformatf("rand%0d f%0d %h,%h", n, f, a, b), f, a, b, model(f, a, b), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
